// File: rtl/kgp_mem_arbiter.sv
// kgp_mem_arbiter: shares one single-port memory between KGP-RISC fetch and load/store,
// data-first with a run-length guard so fetch cannot starve behind long data bursts.
module kgp_mem_arbiter #(
   parameter int AW           = 10,
   parameter int DW           = 32,
   parameter int MAX_DATA_RUN = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_rvalid,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_rvalid,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   input  logic          mem_ready,
   output logic          busy
);
   typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
   localparam logic [3:0] MAX_RUN = 4'(MAX_DATA_RUN);
   state_t     state_q, state_d;
   logic [3:0] run_cnt_q, run_cnt_d;
   logic       done, arb, gnt_d, gnt_f;
   always_comb begin
      done      = (state_q != IDLE) && mem_ready;
      arb       = (state_q == IDLE) || done;
      gnt_d     = arb && d_req && !(if_req && run_cnt_q == MAX_RUN);
      gnt_f     = arb && if_req && !gnt_d;
      state_d   = gnt_d ? DATA : gnt_f ? FETCH : done ? IDLE : state_q;
      run_cnt_d = gnt_f ? 4'd0
                : (gnt_d && if_req && run_cnt_q != MAX_RUN) ? run_cnt_q + 4'd1
                : run_cnt_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         run_cnt_q <= '0;
         if_gnt    <= 1'b0;
         d_gnt     <= 1'b0;
         if_rvalid <= 1'b0;
         d_rvalid  <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
      end else begin
         state_q   <= state_d;
         run_cnt_q <= run_cnt_d;
         if_gnt    <= gnt_f;
         d_gnt     <= gnt_d;
         mem_en    <= state_d != IDLE;
         busy      <= state_d != IDLE;
         if_rvalid <= done && state_q == FETCH;
         d_rvalid  <= done && state_q == DATA;
         if (done && state_q == FETCH) if_rdata <= mem_rdata;
         // mem_we still describes the completing transaction here
         if (done && state_q == DATA && !mem_we) d_rdata <= mem_rdata;
         if (gnt_d) begin
            mem_addr  <= d_addr;
            mem_we    <= d_we;
            mem_wdata <= d_wdata;
         end else if (gnt_f) begin
            mem_addr <= if_addr;
            mem_we   <= 1'b0;
         end else if (done) begin
            mem_we <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_kgp_mem_arbiter.sv
// tb_kgp_mem_arbiter: scoreboard bench with a behavioural memory that answers after a
// programmable number of wait states.
module tb_kgp_mem_arbiter;
   typedef struct {logic we; logic [9:0] addr; logic [31:0] wdata;} mtx_t;
   typedef struct {logic st; logic [31:0] v;} sb_t;
   logic        clk = 0, reset = 0;
   logic        if_req = 0, d_req = 0, d_we = 0, mem_ready = 0;
   logic [9:0]  if_addr = 0, d_addr = 0;
   logic [31:0] d_wdata = 0, mem_rdata = 0;
   logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy;
   logic [31:0] if_rdata, d_rdata, mem_wdata;
   logic [9:0]  mem_addr;
   int          checks = 0, failures = 0;
   int          lat = 0, last_len = 0, rv_cnt = 0, d_rv_cnt = 0, ngr = 0;
   logic [31:0] seq = 0, d_last = 0;
   logic [31:0] mem_model [0:1023];
   sb_t         if_sb[$], d_sb[$];
   mtx_t        if_mq[$], d_mq[$];
   kgp_mem_arbiter #(.AW(10), .DW(32), .MAX_DATA_RUN(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   task automatic f_issue(input logic [9:0] a);
      if_addr = a;
      if_req  = 1;
      if_sb.push_back('{1'b0, mem_model[a]});
      if_mq.push_back('{1'b0, a, 32'h0});
   endtask
   task automatic d_issue(input logic we, input logic [9:0] a, input logic [31:0] wd);
      d_we    = we;
      d_addr  = a;
      d_wdata = wd;
      d_req   = 1;
      d_sb.push_back('{we, mem_model[a]});
      d_mq.push_back('{we, a, wd});
   endtask
   task automatic wait_gnt(input logic fetch, output int cyc);
      bit got = 0;
      cyc = 0;
      for (int n = 0; n < 200 && !got; n++) begin
         @(negedge clk);
         cyc++;
         got = fetch ? if_gnt : d_gnt;
      end
      if (!got) chk(fetch ? "if_gnt_timeout" : "d_gnt_timeout", 0, 1);
      if (fetch) if_req = 0;
      else d_req = 0;
   endtask
   // memory responder: tracks the granted transaction and checks the bus holds steady
   initial begin
      mtx_t cur;
      int   cnt = 0;
      cur = '{1'b0, 10'h0, 32'h0};
      forever begin
         @(negedge clk);
         if (if_gnt && if_mq.size() > 0) begin cur = if_mq.pop_front(); cnt = 0; end
         if (d_gnt && d_mq.size() > 0) begin cur = d_mq.pop_front(); cnt = 0; end
         if (mem_en) begin
            chk("mem_addr", 32'(mem_addr), 32'(cur.addr));
            chk("mem_we", 32'(mem_we), 32'(cur.we));
            if (cur.we) chk("mem_wdata", mem_wdata, cur.wdata);
            mem_ready = (cnt == lat);
            mem_rdata = mem_model[cur.addr];
            if (mem_ready) begin
               if (cur.we) mem_model[cur.addr] = cur.wdata;
               last_len = cnt + 1;
            end
            cnt++;
         end else mem_ready = 0;
      end
   end
   // response monitor and grant recorder
   initial forever begin
      @(negedge clk);
      if (d_gnt) begin seq = {seq[30:0], 1'b0}; ngr++; end
      if (if_gnt) begin seq = {seq[30:0], 1'b1}; ngr++; end
      if (if_rvalid) begin
         rv_cnt++;
         if (if_sb.size() == 0) chk("if_rvalid_unexp", 1, 0);
         else begin
            sb_t e;
            e = if_sb.pop_front();
            chk("if_rdata", if_rdata, e.v);
         end
      end
      if (d_rvalid) begin
         rv_cnt++;
         d_rv_cnt++;
         if (d_sb.size() == 0) chk("d_rvalid_unexp", 1, 0);
         else begin
            sb_t e;
            e = d_sb.pop_front();
            if (!e.st) d_last = e.v;
            chk(e.st ? "d_rdata_store_hold" : "d_rdata_load", d_rdata, d_last);
         end
      end
   end
   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      int c, rv0, drv0;
      for (int i = 0; i < 1024; i++) mem_model[i] = 32'hC0DE0000 ^ (i * 32'h00010007);
      mem_model[10'h010] = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_gnt", {30'h0, if_gnt, d_gnt}, 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_d_rdata", d_rdata, 0);
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      // single fetch, ready in the first mem_en cycle
      f_issue(10'h010);
      @(negedge clk);
      chk("fetch_gnt", 32'(if_gnt), 1);
      chk("fetch_mem_en", 32'(mem_en), 1);
      chk("fetch_mem_addr", 32'(mem_addr), 32'h010);
      chk("fetch_rvalid_early", 32'(if_rvalid), 0);
      if_req = 0;
      @(negedge clk);
      chk("fetch_rvalid", 32'(if_rvalid), 1);
      @(negedge clk);
      chk("fetch_idle", 32'(busy), 0);
      // load then store with three wait states
      d_issue(0, 10'h020, 0);
      wait_gnt(0, c);
      repeat (2) @(negedge clk);
      lat = 3;
      drv0 = d_rv_cnt;
      d_issue(1, 10'h3FF, 32'h12345678);
      wait_gnt(0, c);
      chk("store_gnt_lat", 32'(c), 1);
      repeat (6) @(negedge clk);
      chk("store_len", 32'(last_len), 4);
      chk("store_rvalid_once", 32'(d_rv_cnt - drv0), 1);
      chk("store_model", mem_model[10'h3FF], 32'h12345678);
      // back-to-back loads
      lat = 0;
      d_issue(0, 10'h101, 0);
      wait_gnt(0, c);
      d_issue(0, 10'h102, 0);
      chk("b2b_en1", 32'(mem_en), 1);
      wait_gnt(0, c);
      chk("b2b_gnt_wait", 32'(c), 1);
      chk("b2b_rvalid_with_gnt", 32'(d_rvalid), 1);
      chk("b2b_en2", 32'(mem_en), 1);
      chk("b2b_addr2", 32'(mem_addr), 32'h102);
      repeat (3) @(negedge clk);
      // simultaneous requests with run_cnt == 0
      f_issue(10'h200);
      d_issue(0, 10'h300, 0);
      @(negedge clk);
      chk("prio_d_gnt", 32'(d_gnt), 1);
      chk("prio_if_gnt", 32'(if_gnt), 0);
      d_req = 0;
      @(negedge clk);
      chk("prio_if_gnt_late", 32'(if_gnt), 1);
      chk("prio_d_rvalid", 32'(d_rvalid), 1);
      if_req = 0;
      repeat (3) @(negedge clk);
      // starvation guard: both requesters held continuously
      seq = 0;
      ngr = 0;
      fork
         begin
            int cf;
            for (int i = 0; i < 2; i++) begin f_issue(10'(10'h040 + i)); wait_gnt(1, cf); end
         end
         begin
            int cd;
            for (int i = 0; i < 8; i++) begin d_issue(0, 10'(10'h080 + i), 0); wait_gnt(0, cd); end
         end
      join
      repeat (3) @(negedge clk);
      chk("starve_ngr", 32'(ngr), 10);
      chk("starve_seq", seq, 32'b0000100001);
      // reset in the middle of a long fetch
      lat = 20;
      f_issue(10'h055);
      wait_gnt(1, c);
      repeat (2) @(negedge clk);
      chk("midrst_pre_en", 32'(mem_en), 1);
      reset = 0;
      #1;
      chk("midrst_mem_en", 32'(mem_en), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_mem_addr", 32'(mem_addr), 0);
      chk("midrst_if_rdata", if_rdata, 0);
      chk("midrst_d_rdata", d_rdata, 0);
      if_sb.delete();
      d_sb.delete();
      if_mq.delete();
      d_mq.delete();
      d_last = 0;
      rv0 = rv_cnt;
      repeat (2) @(negedge clk);
      reset = 1;
      repeat (30) @(negedge clk);
      chk("midrst_after_busy", 32'(busy), 0);
      chk("midrst_no_rvalid", 32'(rv_cnt), 32'(rv0));
      chk("sb_empty", 32'(if_sb.size() + d_sb.size()), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/kgp_mem_arbiter.md
# kgp_mem_arbiter

Arbitrates between the KGP-RISC instruction-fetch stage and the load/store stage for one shared single-port memory. Each requester sees a request/grant/response handshake; the memory sees one registered transaction at a time, held until it signals completion. Data accesses win by default. A run-length counter guarantees fetch progress during long load/store bursts.

## Interface
Parameters:
- AW, 10: address width (word address)
- DW, 32: data width
- MAX_DATA_RUN, 4: maximum consecutive data grants while a fetch waits; range 1..15

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  AW  data address
- d_wdata  in  DW  store data
- d_gnt  out  1  one-cycle pulse: data request accepted
- d_rvalid  out  1  one-cycle pulse: load data valid, or store completed
- d_rdata  out  DW  load data; holds last value on store completion
- mem_en  out  1  memory transaction active
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes the current transaction
- busy  out  1  state != IDLE

## Operation
- FSM states: IDLE, FETCH, DATA. Reset forces IDLE. All outputs are registered and reset to 0, including if_rdata, d_rdata, mem_addr and mem_wdata.
- Arbitration occurs in IDLE, and in FETCH or DATA on the completion edge.
  - Grant DATA if d_req=1, unless if_req=1 and run_cnt==MAX_DATA_RUN. In that case, grant FETCH.
  - Otherwise grant FETCH if if_req=1.
  - Otherwise enter or stay in IDLE.
- On a grant:
  - Pulse the matching gnt for one cycle.
  - Latch the address into mem_addr. For DATA, also latch d_we and d_wdata into mem_we and mem_wdata; for FETCH, mem_we=0.
  - Set mem_en=1.
- mem_en, mem_we, mem_addr and mem_wdata hold stable until the edge where mem_ready=1 is sampled. On that edge:
  - FETCH: if_rdata <= mem_rdata and if_rvalid=1 for one cycle.
  - DATA: d_rvalid=1 for one cycle. On a load, also d_rdata <= mem_rdata; on a store, d_rdata is unchanged.
  - mem_en deasserts unless a new grant is made on the same edge.
- mem_ready is ignored while mem_en=0.
- run_cnt (4 bits):
  - Increments, saturating at MAX_DATA_RUN, on a data grant made while if_req=1.
  - Clears to 0 on any fetch grant.
  - Unchanged otherwise.
- Requests arriving while busy wait; they are not queued beyond the requester holding its req.
- A requester must keep req and its addr/data stable from assertion until its gnt pulse. The arbiter samples inputs only on the grant edge.
- Reset mid-transaction aborts the transaction: no rvalid is produced, mem_en drops immediately, and the requester must reissue.

## Timing
- Grant latency: req sampled high at edge k in IDLE gives gnt=1 and mem_en=1 during cycle k+1.
- Response latency: mem_ready sampled high at edge m gives rvalid=1 during cycle m+1.
- Minimum transaction: mem_ready high in the first mem_en cycle gives rvalid two cycles after the request edge.
- Back-to-back: a pending request is granted on the completion edge. rvalid of transaction n and gnt of transaction n+1 occur in the same cycle, and mem_en stays high with the new address.
- Simultaneous if_req and d_req with run_cnt < MAX_DATA_RUN: d_gnt only.

## Test plan
- Reset: reset=0 mid-run with mem_en=1 -> all outputs 0 asynchronously; after release, busy=0 and no rvalid.
- Single fetch: if_req at edge 1, if_addr=0x010, mem_ready high in the first mem_en cycle, mem_rdata=0xDEADBEEF -> if_gnt in cycle 2, mem_addr=0x010, if_rvalid and if_rdata=0xDEADBEEF in cycle 3.
- Store with wait states: d_we=1, d_addr=0x3FF, d_wdata=0x12345678, mem_ready delayed 3 cycles -> mem_en/mem_we/mem_addr/mem_wdata stable 4 cycles; d_rvalid once; d_rdata unchanged.
- Starvation guard: if_req and d_req both held continuously, MAX_DATA_RUN=4 -> grant sequence D,D,D,D,F,D,D,D,D,F.
- Back-to-back: two loads queued, mem_ready=1 always -> d_rvalid of the first coincides with d_gnt of the second; mem_en never drops.
- Priority: if_req and d_req rise together with run_cnt=0 -> d_gnt first, if_gnt on that transaction's completion edge if d_req has dropped.
